axis_frame_gen: RTL and testbench

//  Single-clock AXI4-Stream frame source: emits frames of programmable length carrying a

---
 rtl/axis_frame_gen_pkg.sv | 17 +
 rtl/axis_frame_gen.sv | 211 +++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_pkg.sv
// Shared definitions for the AXI4-Stream frame generator: state encoding and the
// counting pattern that both the generator and any downstream checker recompute.
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Returned wide; callers truncate to their own tdata width, giving (seq + beat) mod 2^W.
    function automatic logic [31:0] pat(input logic [31:0] seq, input logic [31:0] beat);
        return seq + beat;
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame source emitting (frame + beat) counting pattern frames with full tready
// backpressure. Optional inter-frame gap state and gap_cycles port under AXIS_FRAME_GEN_GAP_EN.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   async_rst,
    input  logic                   enable,
    input  logic [LEN_WIDTH-1:0]   frame_len,
    input  logic [LEN_WIDTH-1:0]   frame_count,
`ifdef AXIS_FRAME_GEN_GAP_EN
    input  logic [LEN_WIDTH-1:0]   gap_cycles,
`endif
    input  logic                   user_flag,
    output logic [DATA_WIDTH-1:0]  output_axis_tdata,
    output logic                   output_axis_tvalid,
    input  logic                   output_axis_tready,
    output logic                   output_axis_tlast,
    output logic                   output_axis_tuser,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] frames_sent,
    output state_e                 state_dbg
);

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [LEN_WIDTH-1:0]   seq_q, seq_d;
    logic [LEN_WIDTH-1:0]   beat_q, beat_d;
    logic                   flag_q, flag_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_q, tuser_d;
    logic [COUNT_WIDTH-1:0] frames_q, frames_d;
`ifdef AXIS_FRAME_GEN_GAP_EN
    logic [LEN_WIDTH-1:0]   gap_q, gap_d;
    logic [LEN_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
`endif

    logic                   xfer;
    logic                   launch;
    logic                   halt;
    logic                   next_last;
    logic [LEN_WIDTH-1:0]   beat_nxt;
    logic [LEN_WIDTH-1:0]   seq_nxt;

    // Valid/ready: a beat moves on a rising edge with tvalid & tready; once tvalid is high the
    // beat's tdata/tlast/tuser are frozen and tvalid only falls after that beat has moved.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        seq_d     = seq_q;
        beat_d    = beat_q;
        flag_d    = flag_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        frames_d  = frames_q;
`ifdef AXIS_FRAME_GEN_GAP_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        launch    = 1'b0;
        halt      = 1'b0;
        xfer      = tvalid_q & output_axis_tready;
        beat_nxt  = beat_q + 1'b1;
        seq_nxt   = seq_q + 1'b1;
        next_last = (beat_nxt == (len_q - 1'b1));

        case (state_q)
            ST_IDLE: begin
                if (enable && (frame_len != '0)) begin
                    len_d    = frame_len;
                    count_d  = frame_count;
`ifdef AXIS_FRAME_GEN_GAP_EN
                    gap_d    = gap_cycles;
`endif
                    seq_d    = '0;
                    frames_d = '0;
                    state_d  = ST_RUN;
                    launch   = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (tlast_q) begin
                        frames_d = frames_q + 1'b1;
                        seq_d    = seq_nxt;
                        if ((count_q != '0) && (seq_nxt == count_q)) begin
                            state_d = ST_DONE;
                            halt    = 1'b1;
                        end else if (!enable) begin
                            state_d = ST_IDLE;
                            halt    = 1'b1;
                        end
`ifdef AXIS_FRAME_GEN_GAP_EN
                        else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                            halt      = 1'b1;
                        end
`endif
                        else begin
                            launch = 1'b1;
                        end
                    end else begin
                        beat_d  = beat_nxt;
                        tdata_d = DATA_WIDTH'(pat(32'(seq_q), 32'(beat_nxt)));
                        tlast_d = next_last;
                        tuser_d = next_last & flag_q;
                    end
                end
            end
`ifdef AXIS_FRAME_GEN_GAP_EN
            ST_GAP: begin
                // Exit on the edge that ends the last idle cycle so tvalid rises right after it.
                if (gap_cnt_q == LEN_WIDTH'(1)) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                        launch  = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                halt    = 1'b1;
            end
        endcase

        if (halt) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end

        // First beat of a frame: user_flag is captured here and reused for the whole frame.
        if (launch) begin
            beat_d   = '0;
            flag_d   = user_flag;
            tvalid_d = 1'b1;
            tdata_d  = DATA_WIDTH'(pat(32'(seq_d), 32'd0));
            tlast_d  = (len_d == LEN_WIDTH'(1));
            tuser_d  = (len_d == LEN_WIDTH'(1)) & user_flag;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            beat_q    <= '0;
            flag_q    <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            frames_q  <= '0;
`ifdef AXIS_FRAME_GEN_GAP_EN
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            beat_q    <= beat_d;
            flag_q    <= flag_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            frames_q  <= frames_d;
`ifdef AXIS_FRAME_GEN_GAP_EN
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tlast  = tlast_q;
    assign output_axis_tuser  = tuser_q;
    assign busy               = (state_q == ST_RUN) || (state_q == ST_GAP);
    assign done               = (state_q == ST_DONE);
    assign frames_sent        = frames_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: expected beats are queued as each run is started and
// popped as the stream transfers them. Covers the gap feature when AXIS_FRAME_GEN_GAP_EN is set.
module tb_axis_frame_gen;
    import axis_frame_gen_pkg::*;

    localparam int DW = 8;
    localparam int LW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          enable;
    logic [LW-1:0] frame_len;
    logic [LW-1:0] frame_count;
    logic [LW-1:0] gap_cycles;
    logic          user_flag;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          tuser;
    logic          busy;
    logic          done;
    logic [CW-1:0] frames_sent;
    state_e        state_dbg;

    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] cur_beat;
    logic [DW+1:0] held_beat;
    logic          held_valid = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_xfer = 0;
    int            tready_mode = 0;

    axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
        .clk                (clk),
        .async_rst          (async_rst),
        .enable             (enable),
        .frame_len          (frame_len),
        .frame_count        (frame_count),
`ifdef AXIS_FRAME_GEN_GAP_EN
        .gap_cycles         (gap_cycles),
`endif
        .user_flag          (user_flag),
        .output_axis_tdata  (tdata),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .output_axis_tlast  (tlast),
        .output_axis_tuser  (tuser),
        .busy               (busy),
        .done               (done),
        .frames_sent        (frames_sent),
        .state_dbg          (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference beats for frames first_seq .. first_seq+frames-1 of length len.
    task automatic push_run(input int len, input int frames, input int first_seq, input logic flag);
        for (int s = first_seq; s < first_seq + frames; s++) begin
            for (int k = 0; k < len; k++) begin
                logic          last;
                logic [DW-1:0] d;
                last = (k == len - 1);
                d    = DW'(s + k);
                exp_q.push_back({last & flag, last, d});
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        check_eq({tag, "_done"}, done, 1);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int c = 0;
        while (frames_sent != CW'(n) && c < budget) begin
            tick();
            c++;
        end
        check_eq({tag, "_frames_reached"}, frames_sent, n);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick();
        tick();
    endtask

    // tready changes just after each rising edge so it is stable at the sampling negedge.
    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (async_rst) begin
            held_valid = 1'b0;
        end else if (tvalid) begin
            cur_beat = {tuser, tlast, tdata};
            if (held_valid) check_eq("stall_hold", cur_beat, held_beat);
            if (tready) begin
                n_xfer++;
                if (exp_q.size() == 0) check_eq("extra_beat", exp_q.size(), 1);
                else check_eq("beat", cur_beat, exp_q.pop_front());
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_beat  = cur_beat;
            end
        end else begin
            if (held_valid) check_eq("valid_drop", tvalid, 1);
            held_valid = 1'b0;
        end
    end

    initial begin
        int x0;
        int z;
        async_rst   = 1'b1;
        enable      = 1'b0;
        frame_len   = '0;
        frame_count = '0;
        gap_cycles  = '0;
        user_flag   = 1'b0;
        repeat (3) tick();
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_tdata", tdata, 0);
        check_eq("rst_tlast", tlast, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_frames", frames_sent, 0);
        async_rst = 1'b0;
        tick();

        // 1: two back-to-back frames of four beats, tready held high
        tready_mode = 0;
        push_run(4, 2, 0, 1'b0);
        frame_len   = 4;
        frame_count = 2;
        enable      = 1'b1;
        wait_done("t1", 100);
        check_eq("t1_drained", exp_q.size(), 0);
        check_eq("t1_frames", frames_sent, 2);
        check_eq("t1_state", state_dbg, ST_DONE);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_tvalid", tvalid, 0);
        go_idle();
        check_eq("t1_idle", state_dbg, ST_IDLE);
        check_eq("t1_done_clr", done, 0);

        // 2: single three-beat frame under alternating backpressure
        tready_mode = 1;
        x0          = n_xfer;
        push_run(3, 1, 0, 1'b0);
        frame_len   = 3;
        frame_count = 1;
        enable      = 1'b1;
        wait_done("t2", 100);
        check_eq("t2_xfers", n_xfer - x0, 3);
        check_eq("t2_drained", exp_q.size(), 0);
        go_idle();

        // 3: unlimited run, enable dropped during frame 5 which still completes
        tready_mode = 2;
        push_run(2, 6, 0, 1'b0);
        frame_len   = 2;
        frame_count = 0;
        enable      = 1'b1;
        wait_frames("t3", 5, 500);
        enable = 1'b0;
        z = 0;
        while (busy && z < 200) begin
            tick();
            z++;
        end
        check_eq("t3_stopped", busy, 0);
        tick();
        check_eq("t3_frames", frames_sent, 6);
        check_eq("t3_tvalid", tvalid, 0);
        check_eq("t3_state", state_dbg, ST_IDLE);
        check_eq("t3_drained", exp_q.size(), 0);

        // 4: single-beat frames, each carrying tlast and tuser
        tready_mode = 0;
        push_run(1, 3, 0, 1'b1);
        user_flag   = 1'b1;
        frame_len   = 1;
        frame_count = 3;
        enable      = 1'b1;
        wait_done("t4", 100);
        check_eq("t4_drained", exp_q.size(), 0);
        check_eq("t4_frames", frames_sent, 3);
        user_flag = 1'b0;
        go_idle();

        // 5: asynchronous reset in the middle of a frame, between clock edges
        tready_mode = 0;
        x0          = n_xfer;
        push_run(4, 1, 0, 1'b0);
        frame_len   = 4;
        frame_count = 0;
        enable      = 1'b1;
        z = 0;
        while ((n_xfer - x0) < 2 && z < 100) begin
            tick();
            z++;
        end
        check_eq("t5_progress", n_xfer - x0, 2);
        #2;
        async_rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("t5_rst_tvalid", tvalid, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_state", state_dbg, ST_IDLE);
        enable = 1'b0;
        tick();
        async_rst = 1'b0;
        tick();
        push_run(2, 1, 0, 1'b0);
        frame_len   = 2;
        frame_count = 1;
        enable      = 1'b1;
        wait_done("t5", 100);
        check_eq("t5_drained", exp_q.size(), 0);
        go_idle();

`ifdef AXIS_FRAME_GEN_GAP_EN
        // 6: three idle cycles between two frames
        tready_mode = 0;
        push_run(2, 2, 0, 1'b0);
        frame_len   = 2;
        frame_count = 2;
        gap_cycles  = 3;
        enable      = 1'b1;
        wait_frames("t6", 1, 100);
        z = 0;
        while (!tvalid && z < 20) begin
            z++;
            tick();
        end
        check_eq("t6_gap_len", z, 3);
        wait_done("t6", 100);
        check_eq("t6_drained", exp_q.size(), 0);
        gap_cycles = '0;
        go_idle();
`else
        // 6: zero frame length never starts a run
        frame_len   = 0;
        frame_count = 1;
        enable      = 1'b1;
        repeat (5) tick();
        check_eq("t6_busy", busy, 0);
        check_eq("t6_tvalid", tvalid, 0);
        check_eq("t6_state", state_dbg, ST_IDLE);
        go_idle();
`endif

        check_eq("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
